// File: rtl/key_pkg.sv
// key_pkg: shared repeat-state type and board-clock default timings for the key front end
package key_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_e;
   localparam int DB_CNT_MAX_DEF = 500_000;
   localparam int HOLD_CNT_DEF   = 50_000_000;
   localparam int REP_CNT_DEF    = 10_000_000;
endpackage

// File: rtl/key_chan.sv
// key_chan: one key channel - synchroniser, debounce, edge strobes, toggle and optional hold-to-repeat (KEY_REPEAT_EN)
module key_chan
   import key_pkg::*;
#(
   parameter int DB_CNT_MAX  = DB_CNT_MAX_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CNT    = HOLD_CNT_DEF,
   parameter int REP_CNT     = REP_CNT_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic key_i,
   input  logic tog_clr_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o,
   output logic tog_o,
   output logic rep_o
);
   localparam int CW = $clog2(DB_CNT_MAX + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT_MAX - 1);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic db_q, db_d, dly_q, tog_q, tog_d, s;
   assign s      = sync_q[SYNC_STAGES-1];
   assign db_o   = db_q;
   assign tog_o  = tog_q;
   assign rise_o = db_q & ~dly_q;
   assign fall_o = ~db_q & dly_q;
   // debounce: any agreeing cycle restarts the count, the last disagreeing one adopts s
   always_comb begin
      cnt_d = (s == db_q || cnt_q == DB_LAST) ? '0 : cnt_q + 1'b1;
      db_d  = (s != db_q && cnt_q == DB_LAST) ? s : db_q;
      tog_d = tog_clr_i ? 1'b0 : tog_q ^ rise_o;
   end
   // synchroniser, debounce, edge-delay and toggle state
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
         dly_q  <= 1'b0;
         tog_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         dly_q  <= db_q;
         tog_q  <= tog_d;
      end
   end
`ifdef KEY_REPEAT_EN
   localparam int HM = HOLD_CNT > REP_CNT ? HOLD_CNT : REP_CNT;
   localparam int RW = HM > 1 ? $clog2(HM) : 1;
   rep_state_e st_q, st_d;
   logic [RW-1:0] rc_q, rc_d;
   // repeat FSM: a strobe ends HOLD or a REPEAT period; released key drops to IDLE silently
   always_comb begin
      rep_o = db_q & ((st_q == HOLD && rc_q == RW'(HOLD_CNT - 1)) || (st_q == REPEAT && rc_q == RW'(REP_CNT - 1)));
      st_d  = st_q;
      rc_d  = rc_q + 1'b1;
      if (!db_q) begin
         st_d = IDLE;
         rc_d = '0;
      end else if (st_q == IDLE) begin
         st_d = rise_o ? HOLD : IDLE;
         rc_d = '0;
      end else if (rep_o) begin
         st_d = REPEAT;
         rc_d = '0;
      end
   end
   // repeat state and period counter
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         st_q <= IDLE;
         rc_q <= '0;
      end else begin
         st_q <= st_d;
         rc_q <= rc_d;
      end
   end
`else
   assign rep_o = 1'b0;
`endif
endmodule

// File: rtl/key_debounce_bank.sv
// key_debounce_bank: N_CH independent debounced keys with edge strobes, toggles and optional repeat (KEY_REPEAT_EN)
module key_debounce_bank
   import key_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int DB_CNT_MAX  = DB_CNT_MAX_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CNT    = HOLD_CNT_DEF,
   parameter int REP_CNT     = REP_CNT_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [N_CH-1:0] KEY_IN,
   input  logic [N_CH-1:0] TOG_CLR,
   output logic [N_CH-1:0] KEY_DB,
   output logic [N_CH-1:0] KEY_RISE,
   output logic [N_CH-1:0] KEY_FALL,
   output logic [N_CH-1:0] TOG_Q,
   output logic [N_CH-1:0] KEY_REP,
   output logic            ANY_DB
);
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      key_chan #(
         .DB_CNT_MAX (DB_CNT_MAX),
         .SYNC_STAGES(SYNC_STAGES),
         .HOLD_CNT   (HOLD_CNT),
         .REP_CNT    (REP_CNT)
      ) u_chan (
         .CLK      (CLK),
         .RST      (RST),
         .key_i    (KEY_IN[i]),
         .tog_clr_i(TOG_CLR[i]),
         .db_o     (KEY_DB[i]),
         .rise_o   (KEY_RISE[i]),
         .fall_o   (KEY_FALL[i]),
         .tog_o    (TOG_Q[i]),
         .rep_o    (KEY_REP[i])
      );
   end
   assign ANY_DB = |KEY_DB;
endmodule

// File: tb/tb_key_debounce_bank.sv
// tb_key_debounce_bank: table-driven and scoreboard checks of key_debounce_bank (repeat checks follow KEY_REPEAT_EN)
module tb_key_debounce_bank;
   localparam int N = 4, DB = 4, SY = 2, HOLD = 10, REP = 3;
   logic CLK = 1'b0, RST = 1'b0;
   logic [N-1:0] KEY_IN = '0, TOG_CLR = '0;
   logic [N-1:0] KEY_DB, KEY_RISE, KEY_FALL, TOG_Q, KEY_REP;
   logic ANY_DB;
   typedef struct packed {
      logic [N-1:0] db, rise, fall, tog, rep;
      logic any;
   } obs_t;
   typedef struct {
      logic [N-1:0] key, clr;
      int n;
      logic [N-1:0] exp_db, exp_tog;
   } vec_t;
   obs_t exp_q[$];
   vec_t tbl[16];
   int n_cmp = 0, n_bad = 0;
   bit m_sync[N][SY];
   bit m_db[N], m_dly[N], m_tog[N];
   int m_cnt[N], m_age[N];

   key_debounce_bank #(.N_CH(N), .DB_CNT_MAX(DB), .SYNC_STAGES(SY), .HOLD_CNT(HOLD), .REP_CNT(REP)) dut (
      .CLK(CLK), .RST(RST), .KEY_IN(KEY_IN), .TOG_CLR(TOG_CLR), .KEY_DB(KEY_DB), .KEY_RISE(KEY_RISE),
      .KEY_FALL(KEY_FALL), .TOG_Q(TOG_Q), .KEY_REP(KEY_REP), .ANY_DB(ANY_DB));

   always #5 CLK = ~CLK;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < SY; j++) m_sync[i][j] = 1'b0;
         m_db[i] = 1'b0; m_dly[i] = 1'b0; m_tog[i] = 1'b0; m_cnt[i] = 0; m_age[i] = 0;
      end
   endtask

   task automatic model_edge(input logic [N-1:0] k, input logic [N-1:0] c);
      if (!RST) begin
         model_reset();
         return;
      end
      for (int i = 0; i < N; i++) begin
         bit s, db_old, rise_old;
         s = m_sync[i][SY-1];
         db_old = m_db[i];
         rise_old = m_db[i] & ~m_dly[i];
         m_tog[i] = c[i] ? 1'b0 : m_tog[i] ^ rise_old;
         m_dly[i] = db_old;
         if (s == db_old) m_cnt[i] = 0;
         else if (m_cnt[i] == DB - 1) begin
            m_db[i] = s;
            m_cnt[i] = 0;
         end else m_cnt[i]++;
         for (int j = SY - 1; j > 0; j--) m_sync[i][j] = m_sync[i][j-1];
         m_sync[i][0] = k[i];
         if (m_db[i] && !m_dly[i]) m_age[i] = 0;
         else if (m_db[i]) m_age[i]++;
      end
   endtask

   function automatic obs_t model_out();
      obs_t o = '0;
      for (int i = 0; i < N; i++) begin
         o.db[i] = m_db[i];
         o.rise[i] = m_db[i] & ~m_dly[i];
         o.fall[i] = ~m_db[i] & m_dly[i];
         o.tog[i] = m_tog[i];
`ifdef KEY_REPEAT_EN
         o.rep[i] = m_db[i] && !o.rise[i] && (m_age[i] == HOLD || (m_age[i] > HOLD && (m_age[i] - HOLD) % REP == 0));
`endif
      end
      o.any = |o.db;
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.db = KEY_DB; o.rise = KEY_RISE; o.fall = KEY_FALL; o.tog = TOG_Q; o.rep = KEY_REP; o.any = ANY_DB;
      return o;
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   task automatic check_sb(input string name);
      obs_t e;
      e = exp_q.pop_front();
      cmp(name, 32'(dut_obs()), 32'(e));
   endtask

   task automatic step(input logic [N-1:0] k, input logic [N-1:0] c);
      KEY_IN = k;
      TOG_CLR = c;
      model_edge(k, c);
      exp_q.push_back(model_out());
      @(posedge CLK);
      #1;
      check_sb("cycle");
   endtask

   initial begin
      int cnt, mask;
      bit seen;
      tbl[0]  = '{4'b0001, 4'b0000, 20, 4'b0001, 4'b0001};
      tbl[1]  = '{4'b0000, 4'b0000, 12, 4'b0000, 4'b0001};
      tbl[2]  = '{4'b0001, 4'b0000, 12, 4'b0001, 4'b0000};
      tbl[3]  = '{4'b0000, 4'b0000, 12, 4'b0000, 4'b0000};
      tbl[4]  = '{4'b0010, 4'b0000, 3,  4'b0000, 4'b0000};
      tbl[5]  = '{4'b0000, 4'b0000, 1,  4'b0000, 4'b0000};
      tbl[6]  = '{4'b0010, 4'b0000, 3,  4'b0000, 4'b0000};
      tbl[7]  = '{4'b0010, 4'b0000, 10, 4'b0010, 4'b0010};
      tbl[8]  = '{4'b0000, 4'b0000, 12, 4'b0000, 4'b0010};
      tbl[9]  = '{4'b0100, 4'b0000, 6,  4'b0100, 4'b0010};
      tbl[10] = '{4'b0100, 4'b0100, 1,  4'b0100, 4'b0010};
      tbl[11] = '{4'b0000, 4'b0000, 12, 4'b0000, 4'b0010};
      tbl[12] = '{4'b1001, 4'b0000, 8,  4'b1001, 4'b1011};
      tbl[13] = '{4'b1001, 4'b0000, 30, 4'b1001, 4'b1011};
      tbl[14] = '{4'b0000, 4'b0000, 12, 4'b0000, 4'b1011};
      tbl[15] = '{4'b0000, 4'b1111, 1,  4'b0000, 4'b0000};
      model_reset();
      #1;
      exp_q.push_back(model_out());
      check_sb("reset_state");
      cmp("reset_outputs", 32'(dut_obs()), 32'd0);
      for (int i = 0; i < 3; i++) step(4'b1111, 4'b0000);
      cmp("held_in_reset", 32'(dut_obs()), 32'd0);
      RST = 1'b1;
      for (int t = 0; t < 16; t++) begin
         for (int j = 0; j < tbl[t].n; j++) step(tbl[t].key, tbl[t].clr);
         cmp($sformatf("tbl%0d_db", t), 32'(KEY_DB), 32'(tbl[t].exp_db));
         cmp($sformatf("tbl%0d_tog", t), 32'(TOG_Q), 32'(tbl[t].exp_tog));
      end
      seen = 1'b0;
      for (int j = 0; j < 20 && !seen; j++) begin
         step(4'b1000, 4'b0000);
         seen = KEY_RISE[3];
      end
      cmp("rep_rise_seen", 32'(seen), 32'd1);
      mask = 0;
      for (int j = 1; j <= 20; j++) begin
         step(4'b1000, 4'b0000);
         if (KEY_REP[3]) mask |= 1 << j;
      end
`ifdef KEY_REPEAT_EN
      cmp("rep_offsets", 32'(mask), 32'h0009_2400 | 32'h0008_0000);
`else
      cmp("rep_offsets", 32'(mask), 32'd0);
`endif
      mask = 0;
      for (int j = 0; j < 20; j++) begin
         step(4'b0000, 4'b0000);
         if (KEY_REP[3]) mask |= 1 << j;
      end
      cmp("rep_after_release", 32'(mask), 32'd0);
      cmp("tog3_before_reset", 32'(TOG_Q), 32'b1000);
      for (int j = 0; j < 4; j++) step(4'b0001, 4'b0000);
      #3;
      RST = 1'b0;
      model_reset();
      #1;
      exp_q.push_back(model_out());
      check_sb("async_reset");
      cmp("async_reset_zero", 32'(dut_obs()), 32'd0);
      for (int j = 0; j < 2; j++) step(4'b0001, 4'b0000);
      @(negedge CLK);
      RST = 1'b1;
      cnt = 0;
      seen = 1'b0;
      for (int j = 1; j <= 20 && !seen; j++) begin
         step(4'b0001, 4'b0000);
         if (KEY_DB[0]) begin
            seen = 1'b1;
            cnt = j;
         end
      end
      cmp("post_reset_latency", 32'(cnt), 32'(SY + DB));
      for (int j = 0; j < 3; j++) step(4'b0001, 4'b0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
